// File: rtl/iram_loader_pkg.sv
// Shared types and constants for the IRAM boot loader.
package iram_loader_pkg;

  localparam int DATA_W            = 32;
  localparam int MEM_WORDS_DEFAULT = 1024;

  typedef enum logic [2:0] {
    S_WAIT,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_SWITCH,
    S_RUN
  } state_t;

endpackage

// File: rtl/iram_loader_if.sv
// Program-word stream into the loader: valid/ready with a last marker.
interface iram_loader_if
  import iram_loader_pkg::*;
  ();

  logic              valid;
  logic [DATA_W-1:0] data;
  logic              last;
  logic              ready;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);

endinterface

// File: rtl/iram_loader.sv
// Boot-time IRAM loader: writes streamed program words to consecutive
// addresses, optionally zero-fills the tail, then hands the IRAM port to
// the CPU and releases CPU reset after a short hold.
//
// state    | meaning
// ---------+---------------------------------------------------------
// S_WAIT   | accept next word (or take a zero word when filling)
// S_SETUP  | data/address driven, write strobe still high
// S_STROBE | write strobe low for one cycle
// S_HOLD   | strobe high again, data/address held; decide next step
// S_SWITCH | port handed to CPU, CPU reset held for RESET_HOLD cycles
// S_RUN    | CPU running; terminal until reset
module iram_loader
  import iram_loader_pkg::*;
#(
  parameter int MEM_WORDS  = MEM_WORDS_DEFAULT,
  parameter bit ZERO_FILL  = 1'b1,
  parameter int RESET_HOLD = 2
) (
  input  logic              clk,
  input  logic              reset,
  iram_loader_if.slave      src,
  output logic [31:0]       mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wdata_en,
  output logic              mem_read,
  output logic              mem_write_n,
  output logic              mem_oe,
  output logic              override,
  output logic              cpu_reset,
  output logic              done,
  output logic              overflow
);

  localparam logic [31:0] LAST_ADDR = 32'(MEM_WORDS - 1);
  localparam int          HW        = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;

  state_t        state;
  logic          filling;
  logic          last_q;
  logic          ready_q;
  logic [HW-1:0] hold_cnt;

  assign src.ready = ready_q;

  // Loader FSM; every output is registered alongside the state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= S_WAIT;
      filling      <= 1'b0;
      last_q       <= 1'b0;
      ready_q      <= 1'b0;
      hold_cnt     <= '0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_wdata_en <= 1'b0;
      mem_read     <= 1'b1;
      mem_write_n  <= 1'b1;
      mem_oe       <= 1'b0;
      override     <= 1'b1;
      cpu_reset    <= 1'b1;
      done         <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      case (state)
        S_WAIT: begin
          if (filling) begin
            ready_q      <= 1'b0;
            mem_wdata    <= '0;
            last_q       <= 1'b0;
            mem_wdata_en <= 1'b1;
            mem_write_n  <= 1'b1;
            state        <= S_SETUP;
          end else if (src.valid && ready_q) begin
            ready_q      <= 1'b0;
            mem_wdata    <= src.data;
            last_q       <= src.last;
            mem_wdata_en <= 1'b1;
            mem_write_n  <= 1'b1;
            state        <= S_SETUP;
          end else begin
            ready_q <= 1'b1;
          end
        end
        S_SETUP: begin
          mem_write_n <= 1'b0;
          state       <= S_STROBE;
        end
        S_STROBE: begin
          mem_write_n <= 1'b1;
          state       <= S_HOLD;
        end
        S_HOLD: begin
          // Top of memory ends the load whether or not the stream finished.
          if (mem_addr == LAST_ADDR || (last_q && !ZERO_FILL)) begin
            if (mem_addr == LAST_ADDR && !last_q && !filling) overflow <= 1'b1;
            override     <= 1'b0;
            mem_oe       <= 1'b1;
            mem_wdata_en <= 1'b0;
            mem_read     <= 1'b0;
            ready_q      <= 1'b0;
            hold_cnt     <= HW'(RESET_HOLD - 1);
            state        <= S_SWITCH;
          end else begin
            // Zero-fill keeps in_ready low: the stream is finished.
            if (last_q) filling <= 1'b1;
            mem_addr     <= mem_addr + 32'd1;
            mem_wdata_en <= 1'b0;
            ready_q      <= !(filling || last_q);
            state        <= S_WAIT;
          end
        end
        S_SWITCH: begin
          if (hold_cnt == '0) begin
            cpu_reset <= 1'b0;
            done      <= 1'b1;
            state     <= S_RUN;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        S_RUN: begin
          ready_q <= 1'b0;
        end
        default: state <= S_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_iram_loader.sv
// Directed bench for iram_loader: three configurations (zero-fill, no fill
// with one-cycle CPU reset hold, small memory overflow) driven from one
// stimulus source selected per phase, with an IRAM model per instance.
module tb_iram_loader;

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic [31:0] exp_addr;
  } vec_t;

  localparam logic [31:0] SENT = 32'hDEAD_BEEF;

  logic        clk;
  logic        rst;
  int          sel;
  logic        stim_valid;
  logic [31:0] stim_data;
  logic        stim_last;
  logic        init_ram;

  int n_cmp = 0;
  int n_bad = 0;

  iram_loader_if ifa ();
  iram_loader_if ifb ();
  iram_loader_if ifc ();

  assign ifa.valid = stim_valid && (sel == 0);
  assign ifb.valid = stim_valid && (sel == 1);
  assign ifc.valid = stim_valid && (sel == 2);
  assign ifa.data  = stim_data;
  assign ifb.data  = stim_data;
  assign ifc.data  = stim_data;
  assign ifa.last  = stim_last;
  assign ifb.last  = stim_last;
  assign ifc.last  = stim_last;

  logic [31:0] addr_a, wdata_a, addr_b, wdata_b, addr_c, wdata_c;
  logic en_a, rd_a, wn_a, oe_a, ovr_a, cpur_a, done_a, ovf_a;
  logic en_b, rd_b, wn_b, oe_b, ovr_b, cpur_b, done_b, ovf_b;
  logic en_c, rd_c, wn_c, oe_c, ovr_c, cpur_c, done_c, ovf_c;

  iram_loader #(.MEM_WORDS(8), .ZERO_FILL(1'b1), .RESET_HOLD(2)) dut_a (
    .clk(clk), .reset(rst), .src(ifa.slave),
    .mem_addr(addr_a), .mem_wdata(wdata_a), .mem_wdata_en(en_a), .mem_read(rd_a),
    .mem_write_n(wn_a), .mem_oe(oe_a), .override(ovr_a), .cpu_reset(cpur_a),
    .done(done_a), .overflow(ovf_a)
  );

  iram_loader #(.MEM_WORDS(8), .ZERO_FILL(1'b0), .RESET_HOLD(1)) dut_b (
    .clk(clk), .reset(rst), .src(ifb.slave),
    .mem_addr(addr_b), .mem_wdata(wdata_b), .mem_wdata_en(en_b), .mem_read(rd_b),
    .mem_write_n(wn_b), .mem_oe(oe_b), .override(ovr_b), .cpu_reset(cpur_b),
    .done(done_b), .overflow(ovf_b)
  );

  iram_loader #(.MEM_WORDS(4), .ZERO_FILL(1'b1), .RESET_HOLD(2)) dut_c (
    .clk(clk), .reset(rst), .src(ifc.slave),
    .mem_addr(addr_c), .mem_wdata(wdata_c), .mem_wdata_en(en_c), .mem_read(rd_c),
    .mem_write_n(wn_c), .mem_oe(oe_c), .override(ovr_c), .cpu_reset(cpur_c),
    .done(done_c), .overflow(ovf_c)
  );

  // Selected-instance view used by the shared tasks.
  logic [31:0] cur_addr, cur_wdata;
  logic cur_ready, cur_en, cur_rd, cur_wn, cur_oe, cur_ovr, cur_cpur, cur_done, cur_ovf;

  always_comb begin
    cur_addr = addr_a; cur_wdata = wdata_a; cur_ready = ifa.ready; cur_en = en_a;
    cur_rd = rd_a; cur_wn = wn_a; cur_oe = oe_a; cur_ovr = ovr_a;
    cur_cpur = cpur_a; cur_done = done_a; cur_ovf = ovf_a;
    case (sel)
      1: begin
        cur_addr = addr_b; cur_wdata = wdata_b; cur_ready = ifb.ready; cur_en = en_b;
        cur_rd = rd_b; cur_wn = wn_b; cur_oe = oe_b; cur_ovr = ovr_b;
        cur_cpur = cpur_b; cur_done = done_b; cur_ovf = ovf_b;
      end
      2: begin
        cur_addr = addr_c; cur_wdata = wdata_c; cur_ready = ifc.ready; cur_en = en_c;
        cur_rd = rd_c; cur_wn = wn_c; cur_oe = oe_c; cur_ovr = ovr_c;
        cur_cpur = cpur_c; cur_done = done_c; cur_ovf = ovf_c;
      end
      default: ;
    endcase
  end

  // IRAM models: write on any cycle the active-low strobe is low.
  logic [31:0] ram_a [8];
  logic [31:0] ram_b [8];
  logic [31:0] ram_c [4];
  int pulses_b, pulses_c;

  always @(posedge clk) begin
    if (init_ram) begin
      for (int i = 0; i < 8; i++) begin
        ram_a[i] <= SENT;
        ram_b[i] <= SENT;
      end
      for (int i = 0; i < 4; i++) ram_c[i] <= SENT;
      pulses_b <= 0;
      pulses_c <= 0;
    end else begin
      if (!wn_a) ram_a[addr_a[2:0]] <= wdata_a;
      if (!wn_b) begin
        ram_b[addr_b[2:0]] <= wdata_b;
        pulses_b <= pulses_b + 1;
      end
      if (!wn_c) begin
        ram_c[addr_c[1:0]] <= wdata_c;
        pulses_c <= pulses_c + 1;
      end
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Offer one word; returns at the first SETUP sample when accepted.
  // In toggle mode valid alternates and in_last is driven high while
  // valid is low, which must be ignored.
  task automatic send(input logic [31:0] d, input logic l, input bit toggle, output bit ok);
    int n = 0;
    bit ph = 1'b1;
    stim_data = d;
    while (n < 50) begin
      stim_valid = toggle ? ph : 1'b1;
      stim_last  = stim_valid ? l : 1'b1;
      if (stim_valid && cur_ready) break;
      step();
      ph = !ph;
      n++;
    end
    ok = (n < 50);
    if (ok) step();
    stim_valid = 1'b0;
    stim_last  = 1'b0;
  endtask

  // Send a word and check SETUP/STROBE/HOLD; returns at the HOLD sample.
  task automatic do_word(input string tag, input vec_t v, input bit toggle);
    bit ok;
    send(v.data, v.last, toggle, ok);
    chk({tag, "_accept"}, 32'(ok), 32'd1);
    chk({tag, "_setup_addr"}, cur_addr, v.exp_addr);
    chk({tag, "_setup_data"}, cur_wdata, v.data);
    chk({tag, "_setup_en"}, 32'(cur_en), 32'd1);
    chk({tag, "_setup_wn"}, 32'(cur_wn), 32'd1);
    chk({tag, "_setup_ready"}, 32'(cur_ready), 32'd0);
    step();
    chk({tag, "_strobe_wn"}, 32'(cur_wn), 32'd0);
    chk({tag, "_strobe_ready"}, 32'(cur_ready), 32'd0);
    chk({tag, "_strobe_addr"}, cur_addr, v.exp_addr);
    step();
    chk({tag, "_hold_wn"}, 32'(cur_wn), 32'd1);
    chk({tag, "_hold_en"}, 32'(cur_en), 32'd1);
    chk({tag, "_hold_data"}, cur_wdata, v.data);
    chk({tag, "_hold_ready"}, 32'(cur_ready), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ready"}, 32'(cur_ready), 32'd0);
    chk({tag, "_addr"}, cur_addr, 32'd0);
    chk({tag, "_wdata"}, cur_wdata, 32'd0);
    chk({tag, "_en"}, 32'(cur_en), 32'd0);
    chk({tag, "_read"}, 32'(cur_rd), 32'd1);
    chk({tag, "_wn"}, 32'(cur_wn), 32'd1);
    chk({tag, "_oe"}, 32'(cur_oe), 32'd0);
    chk({tag, "_override"}, 32'(cur_ovr), 32'd1);
    chk({tag, "_cpu_reset"}, 32'(cur_cpur), 32'd1);
    chk({tag, "_done"}, 32'(cur_done), 32'd0);
    chk({tag, "_overflow"}, 32'(cur_ovf), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [4];
    vec_t cvec [6];
    logic [31:0] exp_a [8];
    bit ok;
    int n;

    vecs[0] = '{32'h2001_0005, 1'b0, 32'd0};
    vecs[1] = '{32'h2002_0003, 1'b0, 32'd1};
    vecs[2] = '{32'h0022_1820, 1'b0, 32'd2};
    vecs[3] = '{32'hAC03_0000, 1'b1, 32'd3};
    for (int i = 0; i < 6; i++) cvec[i] = '{32'h1000_0000 + 32'(i), 1'b0, 32'(i)};
    for (int i = 0; i < 8; i++) exp_a[i] = (i < 4) ? vecs[i].data : 32'd0;

    init_ram = 1'b1; sel = 0; stim_valid = 1'b0; stim_data = '0; stim_last = 1'b0; rst = 1'b0;
    repeat (3) step();
    init_ram = 1'b0;

    // Reset values on all three instances.
    for (int i = 0; i < 3; i++) begin
      sel = i;
      #1;
      check_reset_vals($sformatf("rst%0d", i));
    end
    sel = 0;
    #1;
    rst = 1'b1;
    step();
    chk("a_ready_after_reset", 32'(cur_ready), 32'd1);

    // Reset asserted during the strobe of word 2.
    send(vecs[0].data, 1'b0, 1'b0, ok);
    chk("mid_w1_accept", 32'(ok), 32'd1);
    step(); step();
    send(vecs[1].data, 1'b0, 1'b0, ok);
    chk("mid_w2_accept", 32'(ok), 32'd1);
    step();
    chk("mid_strobe_wn", 32'(cur_wn), 32'd0);
    chk("mid_strobe_addr", cur_addr, 32'd1);
    rst = 1'b0;
    step();
    chk("mid_rst_wn", 32'(cur_wn), 32'd1);
    chk("mid_rst_override", 32'(cur_ovr), 32'd1);
    chk("mid_rst_cpu_reset", 32'(cur_cpur), 32'd1);
    chk("mid_rst_addr", cur_addr, 32'd0);
    chk("mid_rst_en", 32'(cur_en), 32'd0);
    rst = 1'b1;
    step();
    chk("mid_ready_again", 32'(cur_ready), 32'd1);

    // Config A: full load with zero fill.
    for (int i = 0; i < 4; i++) do_word($sformatf("a%0d", i), vecs[i], 1'b0);
    step();
    chk("a_fill_ready", 32'(cur_ready), 32'd0);
    chk("a_fill_addr", cur_addr, 32'd4);
    chk("a_fill_override", 32'(cur_ovr), 32'd1);
    n = 0;
    while (cur_ovr && n < 100) begin
      step();
      n++;
    end
    chk("a_switch_override", 32'(cur_ovr), 32'd0);
    chk("a_switch_oe", 32'(cur_oe), 32'd1);
    chk("a_switch_read", 32'(cur_rd), 32'd0);
    chk("a_switch_en", 32'(cur_en), 32'd0);
    chk("a_switch_cpu_reset", 32'(cur_cpur), 32'd1);
    chk("a_switch_done", 32'(cur_done), 32'd0);
    step();
    chk("a_sw1_cpu_reset", 32'(cur_cpur), 32'd1);
    chk("a_sw1_done", 32'(cur_done), 32'd0);
    step();
    chk("a_sw2_cpu_reset", 32'(cur_cpur), 32'd0);
    chk("a_sw2_done", 32'(cur_done), 32'd1);
    chk("a_overflow", 32'(cur_ovf), 32'd0);
    chk("a_run_ready", 32'(cur_ready), 32'd0);
    for (int i = 0; i < 8; i++) chk($sformatf("a_ram%0d", i), ram_a[i], exp_a[i]);

    // Config B: no fill, toggled valid, one-cycle CPU reset hold.
    sel = 1;
    #1;
    for (int i = 0; i < 4; i++) do_word($sformatf("b%0d", i), vecs[i], 1'b1);
    step();
    chk("b_override_after_hold4", 32'(cur_ovr), 32'd0);
    chk("b_sw0_cpu_reset", 32'(cur_cpur), 32'd1);
    chk("b_sw0_done", 32'(cur_done), 32'd0);
    step();
    chk("b_sw1_cpu_reset", 32'(cur_cpur), 32'd0);
    chk("b_sw1_done", 32'(cur_done), 32'd1);
    chk("b_overflow", 32'(cur_ovf), 32'd0);
    chk("b_pulses", 32'(pulses_b), 32'd4);
    for (int i = 0; i < 8; i++)
      chk($sformatf("b_ram%0d", i), ram_b[i], (i < 4) ? vecs[i].data : SENT);

    // Config C: 4-word memory, six words without in_last.
    sel = 2;
    #1;
    for (int i = 0; i < 4; i++) do_word($sformatf("c%0d", i), cvec[i], 1'b0);
    step();
    chk("c_override", 32'(cur_ovr), 32'd0);
    chk("c_overflow", 32'(cur_ovf), 32'd1);
    send(cvec[4].data, 1'b0, 1'b0, ok);
    chk("c_word5_rejected", 32'(ok), 32'd0);
    send(cvec[5].data, 1'b0, 1'b0, ok);
    chk("c_word6_rejected", 32'(ok), 32'd0);
    chk("c_done", 32'(cur_done), 32'd1);
    chk("c_cpu_reset", 32'(cur_cpur), 32'd0);
    chk("c_overflow_sticky", 32'(cur_ovf), 32'd1);
    chk("c_pulses", 32'(pulses_c), 32'd4);
    for (int i = 0; i < 4; i++) chk($sformatf("c_ram%0d", i), ram_c[i], cvec[i].data);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
